// File: rtl/mdu_unit_pkg.sv
// mdu_unit_pkg
//   Shared opcode encoding and helpers for the multiply/divide unit.
//   Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
//   mdu_op_e    : 4-bit MDU operation codes driven from the E stage.
//   is_md_op()  : true for ops that occupy the unit for multiple cycles.
package mdu_unit_pkg;

    typedef enum logic [3:0] {
        MDU_OP_NONE  = 4'd0,
        MDU_OP_MULT  = 4'd1,
        MDU_OP_MULTU = 4'd2,
        MDU_OP_DIV   = 4'd3,
        MDU_OP_DIVU  = 4'd4,
        MDU_OP_MFHI  = 4'd5,
        MDU_OP_MFLO  = 4'd6,
        MDU_OP_MTHI  = 4'd7,
        MDU_OP_MTLO  = 4'd8,
        MDU_OP_MADD  = 4'd9,
        MDU_OP_MADDU = 4'd10,
        MDU_OP_MSUB  = 4'd11,
        MDU_OP_MSUBU = 4'd12
    } mdu_op_e;

    // Multi-cycle ops: these drive stall_md in their issue cycle.
    function automatic logic is_md_op(input logic [3:0] op);
        logic md;
        md = (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
             (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
`ifdef MDU_MADD_EN
        md = md || (op == MDU_OP_MADD) || (op == MDU_OP_MADDU) ||
                   (op == MDU_OP_MSUB) || (op == MDU_OP_MSUBU);
`endif
        return md;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith
//   Combinational datapath of the MDU: computes the pending {phi,plo} result.
//   Product and accumulate are formed at 2*WIDTH; division works on operand
//   magnitudes and restores signs afterwards (truncation toward zero,
//   remainder follows the dividend).
//   Ports:
//     op       in  4      MDU op code
//     a, b     in  WIDTH  rs / rt operands
//     hi, lo   in  WIDTH  committed HI/LO (accumulate base)
//     phi, plo out WIDTH  pending HI/LO result
module mdu_arith
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] phi,
    output logic [WIDTH-1:0] plo
);
    localparam int W2 = 2 * WIDTH;

    logic             is_signed;
    logic [W2-1:0]    a_ext, b_ext, prod, res;
    logic [WIDTH-1:0] a_mag, b_mag, quot, rem;
    logic             neg_q, neg_r;

    always_comb begin
        is_signed = (op == MDU_OP_MULT) || (op == MDU_OP_DIV) ||
                    (op == MDU_OP_MADD) || (op == MDU_OP_MSUB);
        a_ext = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        // Low 2*WIDTH bits of the extended product equal the signed product.
        prod  = a_ext * b_ext;

        neg_q = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r = is_signed && a[WIDTH-1];
        a_mag = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        // A zero divisor never starts an op; substitute 1 to keep values defined.
        if (b == '0) begin
            b_mag = WIDTH'(1);
        end
        // MIN magnitude wraps back to MIN as unsigned, so MIN/-1 yields MIN rem 0.
        quot = a_mag / b_mag;
        rem  = a_mag % b_mag;
        if (neg_q) quot = ~quot + WIDTH'(1);
        if (neg_r) rem  = ~rem + WIDTH'(1);

        case (op)
            MDU_OP_MULT, MDU_OP_MULTU: res = prod;
            MDU_OP_DIV,  MDU_OP_DIVU:  res = {rem, quot};
            MDU_OP_MADD, MDU_OP_MADDU: res = {hi, lo} + prod;
            MDU_OP_MSUB, MDU_OP_MSUBU: res = {hi, lo} - prod;
            default:                   res = {hi, lo};
        endcase
        phi = res[W2-1:WIDTH];
        plo = res[WIDTH-1:0];
    end
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit
//   Multi-cycle multiply/divide unit with HI/LO registers (E stage).
//   Optional feature macro: MDU_MADD_EN (multiply-accumulate ops).
//   Ports:
//     clk       in  1      rising-edge clock
//     reset_n   in  1      asynchronous active-low reset
//     start     in  1      op valid, one-cycle pulse per instruction
//     op        in  4      MDU op code
//     a, b      in  WIDTH  rs / rt operands
//     busy      out 1      operation in flight
//     stall_md  out 1      multi-cycle op issuing or in flight
//     hi, lo    out WIDTH  committed HI/LO
//     rdata     out WIDTH  MFHI/MFLO read data, else 0
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall_md,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] phi_reg, phi_next, plo_reg, plo_next;
    logic [WIDTH-1:0] hi_reg, hi_next, lo_reg, lo_next;
    logic [WIDTH-1:0] arith_hi, arith_lo;
    state_e           state;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op  (op),
        .a   (a),
        .b   (b),
        .hi  (hi_reg),
        .lo  (lo_reg),
        .phi (arith_hi),
        .plo (arith_lo)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
            phi_reg <= '0;
            plo_reg <= '0;
            hi_reg  <= '0;
            lo_reg  <= '0;
        end else begin
            cnt_reg <= cnt_next;
            phi_reg <= phi_next;
            plo_reg <= plo_next;
            hi_reg  <= hi_next;
            lo_reg  <= lo_next;
        end
    end

    // The counter is the state: zero means idle.
    assign state = (cnt_reg == '0) ? ST_IDLE : ST_RUN;

    always_comb begin
        cnt_next = cnt_reg;
        phi_next = phi_reg;
        plo_next = plo_reg;
        hi_next  = hi_reg;
        lo_next  = lo_reg;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MDU_OP_MULT, MDU_OP_MULTU: begin
                            phi_next = arith_hi;
                            plo_next = arith_lo;
                            cnt_next = CW'(MULT_CYCLES);
                        end
                        MDU_OP_DIV, MDU_OP_DIVU: begin
                            if (b != '0) begin
                                phi_next = arith_hi;
                                plo_next = arith_lo;
                                cnt_next = CW'(DIV_CYCLES);
                            end
                        end
`ifdef MDU_MADD_EN
                        MDU_OP_MADD, MDU_OP_MADDU, MDU_OP_MSUB, MDU_OP_MSUBU: begin
                            phi_next = arith_hi;
                            plo_next = arith_lo;
                            cnt_next = CW'(MULT_CYCLES);
                        end
`endif
                        MDU_OP_MTHI: hi_next = a;
                        MDU_OP_MTLO: lo_next = a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // Starts arriving while running are dropped.
                if (cnt_reg == CW'(1)) begin
                    hi_next  = phi_reg;
                    lo_next  = plo_reg;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: ;
        endcase
    end

    assign busy     = (state == ST_RUN);
    assign stall_md = (start && is_md_op(op)) || busy;
    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign rdata    = (op == MDU_OP_MFHI) ? hi_reg :
                      (op == MDU_OP_MFLO) ? lo_reg : '0;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit
//   Directed-vector scoreboard bench for mdu_unit. Expected HI/LO and busy
//   length of each multi-cycle op are queued at issue; a monitor pops and
//   compares when busy falls. Immediate effects (MT*/MF*, reset, stall_md)
//   are compared inline.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        busy, stall_md;
    logic [31:0] hi, lo, rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb[$];

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo),
        .rdata    (rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: completion of a multi-cycle op is the falling edge of busy.
    logic busy_prev = 1'b0;
    int   busy_cnt  = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_prev = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (busy) begin
                busy_cnt++;
            end else if (busy_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit actual=hi %h lo %h required=no op", hi, lo);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("TXN %s hi=%h lo=%h busy_cycles=%0d", e.name, hi, lo, busy_cnt);
                    chk({e.name, "_hi"}, hi, e.hi);
                    chk({e.name, "_lo"}, lo, e.lo);
                    chk({e.name, "_cycles"}, busy_cnt, e.cycles);
                end
                busy_cnt = 0;
            end
            busy_prev = busy;
        end
    end

    task automatic issue(input string name, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic exp_stall);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        #1;
        chk({name, "_stall_md"}, {31'd0, stall_md}, {31'd0, exp_stall});
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = MDU_OP_NONE;
    endtask

    task automatic push(input string name, input logic [31:0] h, input logic [31:0] l,
                        input int cyc);
        exp_t e;
        e.name = name; e.hi = h; e.lo = l; e.cycles = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=busy after %0d cycles required=idle", name, n);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic expect_no_busy(input string name, input int cyc);
        logic seen = 1'b0;
        repeat (cyc) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        chk({name, "_busy_seen"}, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = MDU_OP_NONE;
        a       = '0;
        b       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall_md}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset_n = 1'b1;

        // Signed multiply, with an MFLO read while it runs.
        push("mult_m3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
        issue("mult_m3x7", MDU_OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
        op = MDU_OP_MFLO;
        #1;
        chk("mflo_during_run", rdata, 32'd0);
        chk("busy_during_run", {31'd0, busy}, 32'd1);
        chk("stall_during_run", {31'd0, stall_md}, 32'd1);
        op = MDU_OP_NONE;
        wait_done("mult_m3x7");

        push("divu_100_7", 32'd2, 32'd14, 10);
        issue("divu_100_7", MDU_OP_DIVU, 32'd100, 32'd7, 1'b1);
        wait_done("divu_100_7");

        push("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue("div_m7_2", MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done("div_m7_2");

        push("div_min_m1", 32'd0, 32'h8000_0000, 10);
        issue("div_min_m1", MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done("div_min_m1");

        push("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 5);
        issue("multu_max", MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("multu_max");

        push("mult_m1xm1", 32'd0, 32'd1, 5);
        issue("mult_m1xm1", MDU_OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("mult_m1xm1");

        // Divide by zero leaves everything untouched.
        issue("mthi5", MDU_OP_MTHI, 32'd5, 32'd0, 1'b0);
        issue("mtlo5", MDU_OP_MTLO, 32'd5, 32'd0, 1'b0);
        issue("div_by0", MDU_OP_DIV, 32'd9, 32'd0, 1'b1);
        expect_no_busy("div_by0", 12);
        chk("div_by0_hi", hi, 32'd5);
        chk("div_by0_lo", lo, 32'd5);
        $display("TXN div_by0 hi=%h lo=%h", hi, lo);

        // MTHI then MFHI on the following cycle.
        issue("mthi1234", MDU_OP_MTHI, 32'h1234, 32'd0, 1'b0);
        op = MDU_OP_MFHI;
        #1;
        chk("mfhi_after_mthi", rdata, 32'h1234);
        $display("TXN mfhi rdata=%h", rdata);
        op = MDU_OP_NONE;

        // Starts while busy are dropped.
        push("mult_3x4", 32'd0, 32'd12, 5);
        issue("mult_3x4", MDU_OP_MULT, 32'd3, 32'd4, 1'b1);
        issue("mthi_busy", MDU_OP_MTHI, 32'hFF, 32'd0, 1'b1);
        issue("divu_busy", MDU_OP_DIVU, 32'd9, 32'd3, 1'b1);
        wait_done("mult_3x4");

        // Reset while a multiply is at cnt==3.
        issue("mult_rst", MDU_OP_MULT, 32'd2, 32'd3, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd12 & 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        expect_no_busy("after_rst", 8);
        chk("after_rst_hi", hi, 32'd0);
        chk("after_rst_lo", lo, 32'd0);
        $display("TXN reset_mid_op hi=%h lo=%h", hi, lo);

        // Multiply-accumulate (or its absence).
        issue("mtlo_ff", MDU_OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
        chk("mtlo_ff_lo", lo, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        push("maddu_1x1", 32'd1, 32'd0, 5);
        issue("maddu_1x1", MDU_OP_MADDU, 32'd1, 32'd1, 1'b1);
        wait_done("maddu_1x1");
`else
        issue("maddu_off", MDU_OP_MADDU, 32'd1, 32'd1, 1'b0);
        expect_no_busy("maddu_off", 8);
        chk("maddu_off_hi", hi, 32'd0);
        chk("maddu_off_lo", lo, 32'hFFFF_FFFF);
        $display("TXN maddu_off hi=%h lo=%h", hi, lo);
`endif

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
